vector_to_degree: RTL and testbench
===================================

Name: vector_to_degree

Overview:
- Inverse of the 5-degree sin/cos lookup used for hook swing and motion.
- Takes a signed 2-D offset in sign-magnitude form, e.g. hook-to-target or cursor delta, with 1 = positive.
- Returns the 5-degree step angle whose direction best matches the offset.
- Sequential brute-force search, one candidate per clock, with a start/done handshake toward the game controller FSM.

Parameters:
- MAG_W, 9, width of dx/dy magnitude inputs.
- DEG_W, 9, width of degree output (0..355).
- STEPS, 72, number of candidate angles (360/5).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- dx  in  MAG_W  x offset magnitude.
- dxSign  in  1  x sign, 1 = positive.
- dy  in  MAG_W  y offset magnitude.
- dySign  in  1  y sign, 1 = positive.
- degree  out  DEG_W  result, multiple of 5 in 0..355; holds until next done.
- done  out  1  one-cycle pulse when degree/zero are valid.
- busy  out  1  high from the capture edge until done deasserts.
- zero  out  1  result flag: input vector was (0,0).

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - degree=0, done=0, busy=0, zero=0.
  - Internal index, best score and best index cleared.
  - Reset mid-scan aborts with no done.
- States: IDLE, SCAN, FINISH.
- IDLE:
  - On an edge with start=1, register dx, dxSign, dy and dySign.
  - If dx=dy=0, go to FINISH with zero_next=1 and best index 0.
  - Otherwise go to SCAN with k=0, best=most-negative score, best index 0, zero_next=0.
  - busy=1 from this edge.
- SCAN:
  - Each cycle evaluate candidate k.
  - Score = sc*cos(k)*dx + ss*sin(k)*dy, where sc and ss are ±1 from the table sign XNOR the input sign.
  - Arithmetic: 19-bit signed. Products ≤ 100*511, sum ≤ 102200.
  - Update best only if score > best (strict). On ties the lowest k wins.
  - After k=71 is evaluated, go to FINISH.
  - Scan length is exactly 72 cycles.
- FINISH (one cycle):
  - degree = best index * 5 (shift-add, no multiplier).
  - zero = zero_next, done=1.
  - Next edge: done=0, busy=0, state=IDLE.
- Latency:
  - Non-zero vector: done high in the cycle starting 73 edges after the capture edge.
  - Zero vector: done 1 edge after capture.
- start during SCAN or FINISH is ignored, not queued.
- start held high re-triggers on the first IDLE cycle after done.
- Inputs are registered at capture, so changes during SCAN have no effect.
- Magnitudes beyond table range are fine; no saturation is needed at the given widths.

Decomposition:
- Shared package/header:
  - STEPS, the step size 5, SCORE_W=19.
  - State encodings IDLE/SCAN/FINISH.
  - First-quadrant magnitude constants for 0..90 in steps of 5: 100,99,98,96,93,90,86,81,76,70,64,57,50,42,34,25,17,8,0.
- Sub-module angle_step_table:
  - Combinational.
  - Index 0..71 -> cos/sin magnitudes and sign bits by quadrant mirroring of the constants.
  - Quadrant signs:
    - 0..90: cos+, sin+.
    - 95..180: cos-, sin+.
    - 185..265: cos-, sin-.
    - 270..355: cos+, sin-.
- Top block holds the FSM, counter, score datapath and best register.

Test Plan:
- dx=100+, dy=0 -> degree=0, zero=0; done exactly 73 edges after the start edge; busy high throughout.
- dx=0, dy=50+ -> degree=90 (score 5000 beats 4950 at 85).
- dx=50-, dy=86- -> degree=240 (score 9896 beats 9840 at 245 and 9816 at 235).
- Tie: dx=70-, dy=70- -> degree=220, since 220, 225 and 230 all score 9800 and the lowest wins.
- dx=0, dy=0 -> zero=1, degree=0, done one edge after capture; then a new start with dx=100- gives degree=180 and clears zero.
- Robustness:
  - Pull resetn low at scan cycle 30: all outputs 0 immediately, no done.
  - Then start dx=100+ while pulsing start again at scan cycle 10: single done, degree=0.

Source files
------------

// File: rtl/vector_to_degree_pkg.sv
// Shared constants, FSM encoding and the first-quadrant magnitude table
// for the 5-degree direction search.
package vector_to_degree_pkg;

  localparam int N_STEPS  = 72;
  localparam int STEP_DEG = 5;
  localparam int SCORE_W  = 19;
  localparam int IDX_W    = 7;
  localparam int MAG_CW   = 7;

  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // cos(5*idx) scaled by 100, for idx 0..18 (0..90 degrees).
  function automatic logic [MAG_CW-1:0] quarter_mag(input logic [IDX_W-1:0] idx);
    case (idx)
      7'd0:    return 7'd100;
      7'd1:    return 7'd99;
      7'd2:    return 7'd98;
      7'd3:    return 7'd96;
      7'd4:    return 7'd93;
      7'd5:    return 7'd90;
      7'd6:    return 7'd86;
      7'd7:    return 7'd81;
      7'd8:    return 7'd76;
      7'd9:    return 7'd70;
      7'd10:   return 7'd64;
      7'd11:   return 7'd57;
      7'd12:   return 7'd50;
      7'd13:   return 7'd42;
      7'd14:   return 7'd34;
      7'd15:   return 7'd25;
      7'd16:   return 7'd17;
      7'd17:   return 7'd8;
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/angle_step_table.sv
// Combinational sin/cos lookup for step index 0..71, built by mirroring the
// first-quadrant magnitudes into the other three quadrants.
module angle_step_table
  import vector_to_degree_pkg::*;
(
  input  logic [IDX_W-1:0]  i_index,
  output logic [MAG_CW-1:0] o_cos_mag,
  output logic              o_cos_pos,
  output logic [MAG_CW-1:0] o_sin_mag,
  output logic              o_sin_pos
);

  logic [IDX_W-1:0] w_cos_ref;
  logic [IDX_W-1:0] w_sin_ref;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_cos_ref = i_index;
    w_sin_ref = 7'd18 - i_index;
    o_cos_pos = 1'b1;
    o_sin_pos = 1'b1;
    if (i_index <= 7'd18) begin
      w_cos_ref = i_index;
      w_sin_ref = 7'd18 - i_index;
    end else if (i_index <= 7'd36) begin
      w_cos_ref = 7'd36 - i_index;
      w_sin_ref = i_index - 7'd18;
      o_cos_pos = 1'b0;
    end else if (i_index <= 7'd53) begin
      w_cos_ref = i_index - 7'd36;
      w_sin_ref = 7'd54 - i_index;
      o_cos_pos = 1'b0;
      o_sin_pos = 1'b0;
    end else begin
      w_cos_ref = 7'd72 - i_index;
      w_sin_ref = i_index - 7'd54;
      o_sin_pos = 1'b0;
    end
  end

  assign o_cos_mag = quarter_mag(w_cos_ref);
  assign o_sin_mag = quarter_mag(w_sin_ref);

endmodule

// File: rtl/vector_to_degree.sv
// Brute-force direction finder: scores all 72 candidate angles against a
// captured sign-magnitude offset, one per clock, and reports the best one.
module vector_to_degree
  import vector_to_degree_pkg::*;
#(
  parameter int MAG_W = 9,
  parameter int DEG_W = 9,
  parameter int STEPS = N_STEPS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [MAG_W-1:0] dx,
  input  logic             dxSign,
  input  logic [MAG_W-1:0] dy,
  input  logic             dySign,
  output logic [DEG_W-1:0] degree,
  output logic             done,
  output logic             busy,
  output logic             zero
);

  state_t                     r_state;
  logic [IDX_W-1:0]           r_k;
  logic signed [SCORE_W-1:0]  r_best_score;
  logic [IDX_W-1:0]           r_best_idx;
  logic                       r_zero_next;
  logic [MAG_W-1:0]           r_dx;
  logic                       r_dx_sign;
  logic [MAG_W-1:0]           r_dy;
  logic                       r_dy_sign;
  logic [DEG_W-1:0]           r_degree;
  logic                       r_done;
  logic                       r_busy;
  logic                       r_zero;

  logic [MAG_CW-1:0]          w_cos_mag;
  logic [MAG_CW-1:0]          w_sin_mag;
  logic                       w_cos_pos;
  logic                       w_sin_pos;
  logic [SCORE_W-1:0]         w_cos_prod;
  logic [SCORE_W-1:0]         w_sin_prod;
  logic signed [SCORE_W-1:0]  w_cos_term;
  logic signed [SCORE_W-1:0]  w_sin_term;
  logic signed [SCORE_W-1:0]  w_score;
  logic [DEG_W-1:0]           w_degree;

  angle_step_table u_table (
    .i_index   (r_k),
    .o_cos_mag (w_cos_mag),
    .o_cos_pos (w_cos_pos),
    .o_sin_mag (w_sin_mag),
    .o_sin_pos (w_sin_pos)
  );

  // A term is positive when the table sign agrees with the input sign.
  assign w_cos_prod = SCORE_W'(w_cos_mag) * SCORE_W'(r_dx);
  assign w_sin_prod = SCORE_W'(w_sin_mag) * SCORE_W'(r_dy);
  assign w_cos_term = (w_cos_pos ~^ r_dx_sign) ? $signed(w_cos_prod) : -$signed(w_cos_prod);
  assign w_sin_term = (w_sin_pos ~^ r_dy_sign) ? $signed(w_sin_prod) : -$signed(w_sin_prod);
  assign w_score    = w_cos_term + w_sin_term;

  // index * 5 as (index << 2) + index.
  assign w_degree = DEG_W'({r_best_idx, 2'b00}) + DEG_W'(r_best_idx);

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_zero_next  <= 1'b0;
      r_dx         <= '0;
      r_dx_sign    <= 1'b0;
      r_dy         <= '0;
      r_dy_sign    <= 1'b0;
      r_degree     <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dx       <= dx;
            r_dx_sign  <= dxSign;
            r_dy       <= dy;
            r_dy_sign  <= dySign;
            r_busy     <= 1'b1;
            r_best_idx <= '0;
            if (dx == '0 && dy == '0) begin
              r_zero_next <= 1'b1;
              r_state     <= S_FINISH;
            end else begin
              r_zero_next  <= 1'b0;
              r_k          <= '0;
              r_best_score <= SCORE_MIN;
              r_state      <= S_SCAN;
            end
          end
        end

        S_SCAN: begin
          if (w_score > r_best_score) begin
            r_best_score <= w_score;
            r_best_idx   <= r_k;
          end
          if (r_k == IDX_W'(STEPS - 1)) begin
            r_state <= S_FINISH;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end

        S_FINISH: begin
          // First edge publishes the result; the second retires the pulse.
          if (!r_done) begin
            r_degree <= w_degree;
            r_zero   <= r_zero_next;
            r_done   <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign degree = r_degree;
  assign done   = r_done;
  assign busy   = r_busy;
  assign zero   = r_zero;

endmodule

// File: tb/tb_vector_to_degree.sv
// Self-checking bench: a cycle-level behavioural model checks every output on
// every cycle, and directed runs pin the model to hand-computed answers.
module tb_vector_to_degree;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [8:0] dx = '0;
  logic       dx_sign = 1'b0;
  logic [8:0] dy = '0;
  logic       dy_sign = 1'b0;
  logic [8:0] degree;
  logic       done;
  logic       busy;
  logic       zero;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  vector_to_degree dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .dx     (dx),
    .dxSign (dx_sign),
    .dy     (dy),
    .dySign (dy_sign),
    .degree (degree),
    .done   (done),
    .busy   (busy),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  int cq [19] = '{100, 99, 98, 96, 93, 90, 86, 81, 76, 70, 64, 57, 50, 42, 34, 25, 17, 8, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
  endtask

  // Signed cosine of a multiple of 5 degrees, scaled by 100.
  function automatic int cos5(input int a);
    int r;
    r = a % 360;
    if (r > 180) r = 360 - r;
    if (r <= 90) return cq[r / 5];
    return -cq[(180 - r) / 5];
  endfunction

  function automatic int sin5(input int a);
    return cos5((a + 270) % 360);
  endfunction

  function automatic int model_deg(input int mx, input bit sx, input int my, input bit sy);
    int vx, vy, s, best, bk;
    vx = sx ? mx : -mx;
    vy = sy ? my : -my;
    best = -(1 << 18);
    bk = 0;
    for (int k = 0; k < 72; k++) begin
      s = cos5(5 * k) * vx + sin5(5 * k) * vy;
      if (s > best) begin
        best = s;
        bk = k;
      end
    end
    return bk * 5;
  endfunction

  // Cycle-level model and the single per-cycle compare process.
  bit m_busy = 0, m_done = 0, m_zero = 0, p_zero = 0;
  int m_left = 0, m_degree = 0, p_deg = 0;

  always begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_busy = 0; m_done = 0; m_left = 0; m_degree = 0; m_zero = 0;
    end else if (m_busy) begin
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done   = 1;
          m_degree = p_deg;
          m_zero   = p_zero;
        end
      end
    end else if (start) begin
      m_busy = 1;
      p_zero = (dx == 0 && dy == 0);
      p_deg  = p_zero ? 0 : model_deg(int'(dx), dx_sign, int'(dy), dy_sign);
      m_left = p_zero ? 1 : 73;
    end
    #1;
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("degree", 32'(degree), 32'(m_degree));
    check("zero", 32'(zero), 32'(m_zero));
    if (done === 1'b1) n_done++;
  end

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      if (busy === 1'b0 && done === 1'b0) break;
      @(negedge clk);
    end
    if (i == 300) timeout(name);
  endtask

  // Start one request, scramble inputs during the scan, and check the result.
  task automatic run(input string tag, input logic [8:0] x, input logic xs,
                     input logic [8:0] y, input logic ys,
                     input int exp_deg, input logic exp_zero);
    int lat;
    wait_idle({tag, "_idle"});
    @(negedge clk);
    dx = x; dx_sign = xs; dy = y; dy_sign = ys; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dx = 9'($urandom); dy = 9'($urandom);
    dx_sign = 1'($urandom); dy_sign = 1'($urandom);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) break;
    end
    if (lat >= 200) begin
      timeout({tag, "_done"});
    end else begin
      check({tag, "_latency"}, 32'(lat), exp_zero ? 32'd1 : 32'd73);
      check({tag, "_degree"}, 32'(degree), 32'(exp_deg));
      check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, x, y, i;
    bit xs, ys, zf;

    repeat (3) @(negedge clk);
    check("reset_degree", 32'(degree), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_zero", 32'(zero), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Model pins: hand-computed answers.
    check("pin_east", 32'(model_deg(100, 1, 0, 1)), 32'd0);
    check("pin_north", 32'(model_deg(0, 1, 50, 1)), 32'd90);
    check("pin_240", 32'(model_deg(50, 0, 86, 0)), 32'd240);
    check("pin_tie", 32'(model_deg(70, 0, 70, 0)), 32'd220);
    check("pin_west", 32'(model_deg(100, 0, 0, 1)), 32'd180);
    check("pin_score90", 32'(sin5(90) * 50), 32'd5000);
    check("pin_score85", 32'(sin5(85) * 50), 32'd4950);

    run("east", 9'd100, 1'b1, 9'd0, 1'b1, 0, 1'b0);
    run("north", 9'd0, 1'b1, 9'd50, 1'b1, 90, 1'b0);
    run("d240", 9'd50, 1'b0, 9'd86, 1'b0, 240, 1'b0);
    run("tie", 9'd70, 1'b0, 9'd70, 1'b0, 220, 1'b0);
    run("zero", 9'd0, 1'b0, 9'd0, 1'b1, 0, 1'b1);
    run("west", 9'd100, 1'b0, 9'd0, 1'b1, 180, 1'b0);
    run("maxmag", 9'd511, 1'b0, 9'd511, 1'b1, model_deg(511, 0, 511, 1), 1'b0);

    // Reset in the middle of a scan: outputs clear at once, no done.
    wait_idle("abort_idle");
    @(negedge clk);
    dx = 9'd100; dx_sign = 1'b1; dy = 9'd0; dy_sign = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    nd = n_done;
    resetn = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_degree", 32'(degree), 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_done", 32'(n_done), 32'(nd));

    // Extra start pulse mid-scan is ignored: exactly one done.
    nd = n_done;
    @(negedge clk);
    dx = 9'd100; dx_sign = 1'b1; dy = 9'd0; dy_sign = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    dx = 9'd100; dx_sign = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("pulse_single_done", 32'(n_done), 32'(nd + 1));
    check("pulse_degree", 32'(degree), 32'd0);

    // start held high re-triggers right after each done.
    wait_idle("hold_idle");
    nd = n_done;
    @(negedge clk);
    dx = 9'd0; dx_sign = 1'b1; dy = 9'd100; dy_sign = 1'b0; start = 1'b1;
    repeat (149) @(negedge clk);
    check("hold_two_dones", 32'(n_done), 32'(nd + 2));
    check("hold_degree", 32'(degree), 32'd270);
    start = 1'b0;

    // Randomized vectors, expectations from the model only.
    for (i = 0; i < 30; i++) begin
      x = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 511));
      y = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 511));
      xs = 1'($urandom);
      ys = 1'($urandom);
      zf = (x == 0 && y == 0);
      run("rand", 9'(x), xs, 9'(y), ys, zf ? 0 : model_deg(x, xs, y, ys), zf);
    end

    wait_idle("final_idle");
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
